// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, field widths and config normalisation.
package uart_pkg;

  localparam int unsigned BIT_PERIOD_W  = 14;
  localparam int unsigned DATA_SIZE_W   = 4;
  localparam int unsigned DATA_SIZE_MIN = 5;
  localparam int unsigned DATA_SIZE_MAX = 8;
  localparam int unsigned BIT_CNT_W     = 3;
  localparam int unsigned BYTE_W        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A period of 0 behaves like 1 so the timer always expires.
  function automatic logic [BIT_PERIOD_W-1:0] norm_period(input logic [BIT_PERIOD_W-1:0] p);
    return (p == '0) ? BIT_PERIOD_W'(1) : p;
  endfunction

  // Sizes outside 5..8 fall back to a full byte.
  function automatic logic [DATA_SIZE_W-1:0] norm_size(input logic [DATA_SIZE_W-1:0] s);
    return ((s >= DATA_SIZE_W'(DATA_SIZE_MIN)) && (s <= DATA_SIZE_W'(DATA_SIZE_MAX)))
           ? s : DATA_SIZE_W'(DATA_SIZE_MAX);
  endfunction

endpackage

// File: rtl/tx_timer.sv
// Bit-period counter and data-bit counter for the UART transmitter.
module tx_timer
  import uart_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    active_i,
  input  logic                    data_phase_i,
  input  logic [BIT_PERIOD_W-1:0] period_i,
  input  logic [DATA_SIZE_W-1:0]  nbits_i,
  output logic                    bit_done_o,
  output logic                    last_bit_o
);

  logic [BIT_PERIOD_W-1:0] count_q, count_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

  assign bit_done_o = active_i && (count_q == (period_i - BIT_PERIOD_W'(1)));
  assign last_bit_o = (DATA_SIZE_W'(bit_cnt_q) == (nbits_i - DATA_SIZE_W'(1)));

  // Counter reloads at every bit boundary and rests at zero while idle.
  always_comb begin
    count_d   = count_q;
    bit_cnt_d = bit_cnt_q;
    if (!active_i || bit_done_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + BIT_PERIOD_W'(1);
    end
    if (!active_i) begin
      bit_cnt_d = '0;
    end else if (data_phase_i && bit_done_o) begin
      bit_cnt_d = last_bit_o ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/tx_block.sv
// UART transmitter: single-entry holding buffer feeding a start/data/stop frame serialiser.
module tx_block
  import uart_pkg::*;
(
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_load,
  input  logic [BIT_PERIOD_W-1:0] bit_period,
  input  logic [DATA_SIZE_W-1:0]  data_size,
  output logic                    serial_out,
  output logic                    tx_ready,
  output logic                    tx_busy,
  output logic                    load_dropped
);

  tx_state_t               state_q, state_d;
  logic [BYTE_W-1:0]       buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [BYTE_W-1:0]       shift_q, shift_d;
  logic                    serial_q, serial_d;
  logic                    dropped_q, dropped_d;
  logic [BIT_PERIOD_W-1:0] period_q, period_d;
  logic [DATA_SIZE_W-1:0]  nbits_q, nbits_d;
  logic                    xfer;
  logic                    bit_done;
  logic                    last_bit;

  tx_timer u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .active_i     (state_q != IDLE),
    .data_phase_i (state_q == DATA),
    .period_i     (period_q),
    .nbits_i      (nbits_q),
    .bit_done_o   (bit_done),
    .last_bit_o   (last_bit)
  );

  assign serial_out   = serial_q;
  assign tx_ready     = !buf_full_q;
  assign tx_busy      = (state_q != IDLE);
  assign load_dropped = dropped_q;

  // Next-state: buffer write, frame sequencing and buffer-to-shifter transfer.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    serial_d   = serial_q;
    period_d   = period_q;
    nbits_d    = nbits_q;
    dropped_d  = tx_load && buf_full_q;
    xfer       = 1'b0;

    if (tx_load && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        xfer = buf_full_q;
      end
      START: begin
        if (bit_done) begin
          state_d  = DATA;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (last_bit) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (buf_full_q) begin
            xfer = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame configuration is captured once so mid-frame input changes wait for the next frame.
    if (xfer) begin
      state_d    = START;
      shift_d    = buf_q;
      buf_full_d = 1'b0;
      serial_d   = 1'b0;
      period_d   = norm_period(bit_period);
      nbits_d    = norm_size(data_size);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      dropped_q  <= 1'b0;
      period_q   <= BIT_PERIOD_W'(1);
      nbits_q    <= DATA_SIZE_W'(DATA_SIZE_MAX);
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      dropped_q  <= dropped_d;
      period_q   <= period_d;
      nbits_q    <= nbits_d;
    end
  end

endmodule

// File: tb/tb_tx_block.sv
// Bench for tx_block: per-cycle line-waveform reference model plus directed frame decoding.
module tb_tx_block;

  logic        clk;
  logic        n_rst;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        serial_out;
  logic        tx_ready;
  logic        tx_busy;
  logic        load_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: expected line level for every future cycle of queued frames.
  bit       wave[$];
  bit       m_buf_full;
  bit       m_dropped;
  bit [7:0] m_buf;

  int busy_cycles;
  int busy_falls;
  bit prev_busy;

  tx_block dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .bit_period   (bit_period),
    .data_size    (data_size),
    .serial_out   (serial_out),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .load_dropped (load_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit ld, input bit [7:0] d, input bit [13:0] p, input bit [3:0] s);
    bit xfer;
    xfer      = m_buf_full && (wave.size() <= 1);
    m_dropped = ld && m_buf_full;
    if (wave.size() > 0) void'(wave.pop_front());
    if (xfer) begin
      int pp;
      int nn;
      pp = (p == 0) ? 1 : int'(p);
      nn = (s >= 5 && s <= 8) ? int'(s) : 8;
      for (int k = 0; k < pp; k++) wave.push_back(1'b0);
      for (int b = 0; b < nn; b++)
        for (int k = 0; k < pp; k++) wave.push_back(m_buf[b]);
      for (int k = 0; k < pp; k++) wave.push_back(1'b1);
      m_buf_full = 1'b0;
    end else if (ld && !m_buf_full) begin
      m_buf      = d;
      m_buf_full = 1'b1;
    end
  endtask

  task automatic model_reset();
    wave.delete();
    m_buf_full = 1'b0;
    m_dropped  = 1'b0;
  endtask

  task automatic compare_outputs();
    check("serial_out", serial_out, (wave.size() != 0) ? wave[0] : 1'b1);
    check("tx_busy", tx_busy, wave.size() != 0);
    check("tx_ready", tx_ready, !m_buf_full);
    check("load_dropped", load_dropped, m_dropped);
  endtask

  // One clock: apply inputs, step the model over the edge, compare just after it.
  task automatic step(input bit ld, input bit [7:0] d);
    tx_load = ld;
    tx_data = d;
    @(posedge clk);
    #1;
    model_edge(ld, d, bit_period, data_size);
    compare_outputs();
    if (tx_busy) busy_cycles++;
    if (prev_busy && !tx_busy) busy_falls++;
    prev_busy = tx_busy;
    tx_load   = 1'b0;
  endtask

  task automatic frame_test(input string tag, input bit [7:0] b, input int p, input int n);
    bit       samp[$];
    bit [7:0] rx;
    bit [7:0] mask;
    int       busy_n;
    bit_period = 14'(p);
    data_size  = 4'(n);
    step(1'b1, b);
    check({tag, " ready_n1"}, tx_ready, 1'b0);
    busy_n = 0;
    for (int i = 0; i < (2 + n) * p + 4; i++) begin
      step(1'b0, 8'h00);
      samp.push_back(serial_out);
      if (tx_busy) busy_n++;
      if (i == 0) begin
        check({tag, " start_n2"}, serial_out, 1'b0);
        check({tag, " busy_n2"}, tx_busy, 1'b1);
        check({tag, " ready_n2"}, tx_ready, 1'b1);
      end
    end
    check({tag, " busy_len"}, busy_n, (2 + n) * p);
    rx = 8'h00;
    for (int k = 0; k < n; k++) rx[k] = samp[(1 + k) * p + p / 2];
    mask = 8'((1 << n) - 1);
    check({tag, " rx_data"}, rx, b & mask);
    check({tag, " stop_bit"}, samp[(1 + n) * p + p / 2], 1'b1);
    check({tag, " idle_after"}, samp[(2 + n) * p], 1'b1);
  endtask

  initial begin
    int zeros;
    int guard;
    n_rst      = 1'b0;
    tx_load    = 1'b0;
    tx_data    = 8'h00;
    bit_period = 14'd10;
    data_size  = 4'd8;
    prev_busy  = 1'b0;
    model_reset();
    #12;
    check("rst serial_out", serial_out, 1'b1);
    check("rst tx_ready", tx_ready, 1'b1);
    check("rst tx_busy", tx_busy, 1'b0);
    check("rst load_dropped", load_dropped, 1'b0);
    n_rst = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

    frame_test("a5", 8'hA5, 10, 8);
    frame_test("short", 8'hFF, 4, 5);
    frame_test("loop3c", 8'h3C, 10, 8);
    frame_test("loopc3", 8'hC3, 10, 8);
    frame_test("p0", 8'h6B, 0 + 1, 7);

    // Back-to-back frames with an overflow attempt while the buffer is full.
    bit_period  = 14'd3;
    data_size   = 4'd8;
    busy_cycles = 0;
    busy_falls  = 0;
    step(1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b0, 8'h00);
    step(1'b1, 8'h55);
    check("ovf dropped", load_dropped, 1'b1);
    step(1'b0, 8'h00);
    check("ovf pulse_len", load_dropped, 1'b0);
    guard = 0;
    while (tx_busy && guard < 200) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("b2b timeout", guard < 200, 1'b1);
    check("b2b busy_total", busy_cycles, 60);
    check("b2b busy_falls", busy_falls, 1);

    // Asynchronous reset in the middle of the data bits.
    bit_period = 14'd5;
    step(1'b1, 8'h96);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h11);
    #3;
    n_rst = 1'b0;
    #1;
    model_reset();
    check("mrst serial_out", serial_out, 1'b1);
    check("mrst tx_ready", tx_ready, 1'b1);
    check("mrst tx_busy", tx_busy, 1'b0);
    check("mrst load_dropped", load_dropped, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 8'h00);
      if (!serial_out) zeros++;
    end
    check("mrst silent", zeros, 0);

    // Random loads and mid-frame config changes, including out-of-range sizes and period 0.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bit_period = 14'($urandom_range(0, 6));
        data_size  = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 5) == 0, 8'($urandom));
    end
    guard = 0;
    while ((wave.size() != 0 || m_buf_full) && guard < 1000) begin
      step(1'b0, 8'h00);
      guard++;
    end
    check("drain timeout", guard < 1000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
